// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking stay meter.
// Holds the tick counter modulus/width, the controller state encoding and
// the wrap-aware elapsed-ticks function.
package parking_pkg;

  localparam int unsigned TICK_MOD = 1000;
  localparam int unsigned TICK_W   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Elapsed ticks from stamp to now on the 0..TICK_MOD-1 counter.
  // A stay of TICK_MOD or more ticks aliases modulo TICK_MOD.
  function automatic logic [TICK_W-1:0] elapsed_ticks(
    input logic [TICK_W-1:0] now,
    input logic [TICK_W-1:0] stamp
  );
    logic [TICK_W:0] diff;
    if (now >= stamp) begin
      diff = {1'b0, now} - {1'b0, stamp};
    end else begin
      diff = {1'b0, now} + (TICK_W+1)'(TICK_MOD) - {1'b0, stamp};
    end
    return diff[TICK_W-1:0];
  endfunction

endpackage

// File: rtl/parking_stay_meter_if.sv
// Request/result bundle between the gate front end and the stay meter.
// master: gate/sensor side (drives timer_count and entry/exit requests,
//         receives ready, occupancy, entry_err and the result fields).
// slave : the stay meter itself.
interface parking_stay_meter_if
  import parking_pkg::*;
#(
  parameter int unsigned SLOTS = 8,
  parameter int unsigned FEE_W = 8
) ();

  localparam int unsigned SLOT_W = $clog2(SLOTS);

  logic [TICK_W-1:0] timer_count;
  logic              entry_valid;
  logic [SLOT_W-1:0] entry_slot;
  logic              exit_valid;
  logic [SLOT_W-1:0] exit_slot;
  logic              ready;
  logic [SLOTS-1:0]  occupied;
  logic              entry_err;
  logic              result_valid;
  logic [SLOT_W-1:0] result_slot;
  logic [TICK_W-1:0] result_ticks;
  logic [FEE_W-1:0]  result_fee;
  logic              result_err;

  modport master (
    output timer_count, entry_valid, entry_slot, exit_valid, exit_slot,
    input  ready, occupied, entry_err, result_valid, result_slot,
           result_ticks, result_fee, result_err
  );

  modport slave (
    input  timer_count, entry_valid, entry_slot, exit_valid, exit_slot,
    output ready, occupied, entry_err, result_valid, result_slot,
           result_ticks, result_fee, result_err
  );

endinterface

// File: rtl/parking_fee_divider.sv
// Iterative billing-unit counter: units = max(1, ceil(dividend/UNIT_TICKS)).
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   i_start      : load dividend (rem <- dividend, units <- 1)
//   i_dividend   : elapsed ticks to divide
//   o_done_c     : combinational, high in the last busy cycle
//   o_units      : unit count, valid while o_done_c is high
module parking_fee_divider
  import parking_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [TICK_W-1:0] i_dividend,
  output logic              o_done_c,
  output logic [TICK_W-1:0] o_units
);

  localparam logic [TICK_W-1:0] UNIT = TICK_W'(UNIT_TICKS);

  logic              r_busy;
  logic [TICK_W-1:0] r_rem;
  logic [TICK_W-1:0] r_units;

  // Done is flagged in the same cycle the remainder drops to one unit or less,
  // so the caller can register the result on that edge.
  assign o_done_c = r_busy && (r_rem <= UNIT);
  assign o_units  = r_units;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_rem   <= '0;
      r_units <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_rem   <= i_dividend;
      r_units <= TICK_W'(1);
    end else if (r_busy) begin
      if (r_rem > UNIT) begin
        r_rem   <= r_rem - UNIT;
        r_units <= r_units + TICK_W'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_stay_meter.sv
// Parking stay meter: stamps each car's entry tick per slot and, on exit,
// reports the wrap-aware stay in ticks (and a saturated fee when built with
// PARKING_STAY_FEE_EN defined; otherwise result_fee is tied to 0 and exits
// complete without a CALC phase).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : slave side of parking_stay_meter_if (requests in, results out)
module parking_stay_meter
  import parking_pkg::*;
#(
  parameter int unsigned SLOTS      = 8,
  parameter int unsigned UNIT_TICKS = 100,
  parameter int unsigned RATE       = 5,
  parameter int unsigned FEE_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  parking_stay_meter_if.slave  bus
);

  localparam int unsigned SLOT_W = $clog2(SLOTS);

  state_e            r_state;
  logic [TICK_W-1:0] r_stamp [SLOTS];
  logic [SLOTS-1:0]  r_occ;
  logic              r_ready;
  logic              r_entry_err;
  logic              r_res_valid;
  logic              r_res_err;
  logic [SLOT_W-1:0] r_res_slot;
  logic [TICK_W-1:0] r_res_ticks;

  logic              w_idle;
  logic              w_entry;
  logic              w_exit;
  logic              w_exit_hit;
  logic              w_swap;
  logic              w_entry_ok;
  logic              w_entry_rej;
  logic [TICK_W-1:0] w_elapsed;
  logic [SLOTS-1:0]  w_occ_next;

  // Request decode; all decisions use the occupancy as it was before this edge.
  assign w_idle      = (r_state == IDLE);
  assign w_entry     = w_idle && bus.entry_valid;
  assign w_exit      = w_idle && bus.exit_valid;
  assign w_exit_hit  = w_exit && r_occ[bus.exit_slot];
  // Same-slot entry+exit on an occupied slot hands the slot to the new car.
  assign w_swap      = w_exit_hit && w_entry && (bus.entry_slot == bus.exit_slot);
  assign w_entry_ok  = w_entry && (!r_occ[bus.entry_slot] || w_swap);
  assign w_entry_rej = w_entry && r_occ[bus.entry_slot] && !w_swap;
  assign w_elapsed   = elapsed_ticks(bus.timer_count, r_stamp[bus.exit_slot]);

  // Exit clears first so a same-slot entry leaves the slot occupied.
  always_comb begin
    w_occ_next = r_occ;
    if (w_exit_hit) w_occ_next[bus.exit_slot] = 1'b0;
    if (w_entry_ok) w_occ_next[bus.entry_slot] = 1'b1;
  end

  // Timestamp table; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && w_entry_ok) begin
      r_stamp[bus.entry_slot] <= bus.timer_count;
    end
  end

`ifdef PARKING_STAY_FEE_EN
  localparam logic [31:0] FEE_MAX = 32'((64'd1 << FEE_W) - 64'd1);

  logic              w_div_done;
  logic [TICK_W-1:0] w_div_units;
  logic [31:0]       w_fee_raw;
  logic [FEE_W-1:0]  w_fee;
  logic [SLOT_W-1:0] r_calc_slot;
  logic [TICK_W-1:0] r_calc_ticks;
  logic [FEE_W-1:0]  r_res_fee;

  // Divider starts on the same edge the FSM enters CALC.
  parking_fee_divider #(
    .UNIT_TICKS (UNIT_TICKS)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_exit_hit),
    .i_dividend (w_elapsed),
    .o_done_c   (w_div_done),
    .o_units    (w_div_units)
  );

  assign w_fee_raw = 32'(w_div_units) * 32'(RATE);
  assign w_fee     = (w_fee_raw > FEE_MAX) ? FEE_W'(FEE_MAX) : FEE_W'(w_fee_raw);
  assign bus.result_fee = r_res_fee;
`else
  logic w_unused_params;
  assign w_unused_params = ^{1'(RATE), 1'(UNIT_TICKS), 1'(FEE_W)};
  assign bus.result_fee  = '0;
`endif

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_occ       <= '0;
      r_ready     <= 1'b1;
      r_entry_err <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_slot  <= '0;
      r_res_ticks <= '0;
`ifdef PARKING_STAY_FEE_EN
      r_res_fee    <= '0;
      r_calc_slot  <= '0;
      r_calc_ticks <= '0;
`endif
    end else begin
      r_occ       <= w_occ_next;
      r_entry_err <= w_entry_rej;
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_exit) begin
`ifdef PARKING_STAY_FEE_EN
            r_ready <= 1'b0;
            if (w_exit_hit) begin
              r_state      <= CALC;
              r_calc_slot  <= bus.exit_slot;
              r_calc_ticks <= w_elapsed;
            end else begin
              r_state     <= DONE;
              r_res_valid <= 1'b1;
              r_res_err   <= 1'b1;
              r_res_slot  <= bus.exit_slot;
              r_res_ticks <= '0;
              r_res_fee   <= '0;
            end
`else
            r_state     <= DONE;
            r_ready     <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_err   <= !w_exit_hit;
            r_res_slot  <= bus.exit_slot;
            r_res_ticks <= w_exit_hit ? w_elapsed : '0;
`endif
          end
        end
`ifdef PARKING_STAY_FEE_EN
        CALC: begin
          if (w_div_done) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b0;
            r_res_slot  <= r_calc_slot;
            r_res_ticks <= r_calc_ticks;
            r_res_fee   <= w_fee;
          end
        end
`endif
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready        = r_ready;
  assign bus.occupied     = r_occ;
  assign bus.entry_err    = r_entry_err;
  assign bus.result_valid = r_res_valid;
  assign bus.result_slot  = r_res_slot;
  assign bus.result_ticks = r_res_ticks;
  assign bus.result_err   = r_res_err;

endmodule

// File: tb/tb_parking_stay_meter.sv
// Directed bench for parking_stay_meter: main instance (UNIT_TICKS=100) and a
// UNIT_TICKS=1 instance for fee saturation. Expectations follow the
// PARKING_STAY_FEE_EN build setting.
module tb_parking_stay_meter;
  import parking_pkg::*;

`ifdef PARKING_STAY_FEE_EN
  localparam bit FEE_EN = 1'b1;
`else
  localparam bit FEE_EN = 1'b0;
`endif

  localparam int WAIT_LIMIT = 1100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  parking_stay_meter_if #(.SLOTS(8), .FEE_W(8)) bus ();
  parking_stay_meter_if #(.SLOTS(8), .FEE_W(8)) sbus ();

  parking_stay_meter #(.SLOTS(8), .UNIT_TICKS(100), .RATE(5), .FEE_W(8)) u_dut (
    .clk (clk), .reset (reset), .bus (bus)
  );

  parking_stay_meter #(.SLOTS(8), .UNIT_TICKS(1), .RATE(5), .FEE_W(8)) u_dut_sat (
    .clk (clk), .reset (reset), .bus (sbus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns just after that edge.
  task automatic req(input bit ev, input int es, input bit xv, input int xs, input int t);
    bus.entry_valid = ev;
    bus.entry_slot  = 3'(es);
    bus.exit_valid  = xv;
    bus.exit_slot   = 3'(xs);
    bus.timer_count = 10'(t);
    tick();
    bus.entry_valid = 1'b0;
    bus.exit_valid  = 1'b0;
  endtask

  // Called just after the sampling edge of an exit.
  task automatic expect_result(input string tag, input int slot, input int ticks,
                               input int units, input int fee, input bit err);
    int k;
    int lat;
    int exp_fee;
    k       = 0;
    lat     = (err || !FEE_EN) ? 0 : units;
    exp_fee = (err || !FEE_EN) ? 0 : fee;
    chk({tag, "_ready_busy"}, 32'(bus.ready), 0);
    while (bus.result_valid !== 1'b1 && k < WAIT_LIMIT) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 32'(bus.result_valid), 1);
    chk({tag, "_latency"}, 32'(k), 32'(lat));
    chk({tag, "_slot"}, 32'(bus.result_slot), 32'(slot));
    chk({tag, "_ticks"}, 32'(bus.result_ticks), 32'(ticks));
    chk({tag, "_fee"}, 32'(bus.result_fee), 32'(exp_fee));
    chk({tag, "_err"}, 32'(bus.result_err), 32'(err));
    chk({tag, "_ready_done"}, 32'(bus.ready), 0);
    tick();
    chk({tag, "_pulse_end"}, 32'(bus.result_valid), 0);
    chk({tag, "_ready_back"}, 32'(bus.ready), 1);
    chk({tag, "_hold_ticks"}, 32'(bus.result_ticks), 32'(ticks));
  endtask

  initial begin
    int k;
    int seen;
    bus.entry_valid = 1'b0; bus.entry_slot = '0;
    bus.exit_valid  = 1'b0; bus.exit_slot  = '0; bus.timer_count = '0;
    sbus.entry_valid = 1'b0; sbus.entry_slot = '0;
    sbus.exit_valid  = 1'b0; sbus.exit_slot  = '0; sbus.timer_count = '0;

    tick();
    tick();
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_occupied", 32'(bus.occupied), 0);
    chk("rst_entry_err", 32'(bus.entry_err), 0);
    chk("rst_result_valid", 32'(bus.result_valid), 0);
    chk("rst_result_slot", 32'(bus.result_slot), 0);
    chk("rst_result_ticks", 32'(bus.result_ticks), 0);
    chk("rst_result_fee", 32'(bus.result_fee), 0);
    chk("rst_result_err", 32'(bus.result_err), 0);
    reset = 1'b1;

    // Wrap-around: 980 -> 30 is 50 ticks.
    req(1, 2, 0, 0, 980);
    chk("wrap_occ_in", 32'(bus.occupied), 32'h04);
    chk("wrap_no_entry_err", 32'(bus.entry_err), 0);
    req(0, 0, 1, 2, 30);
    chk("wrap_occ_out", 32'(bus.occupied), 0);
    expect_result("wrap", 2, 50, 1, 5, 0);

    // Plain stay 100 -> 350: 250 ticks, 3 units.
    req(1, 0, 0, 0, 100);
    req(0, 0, 1, 0, 350);
    expect_result("plain", 0, 250, 3, 15, 0);

    // Exit on empty slot.
    req(0, 0, 1, 5, 400);
    expect_result("empty5", 5, 0, 0, 0, 1);

    // Double entry on slot 5; the original stamp must survive.
    req(1, 5, 0, 0, 200);
    chk("dbl_first_ok", 32'(bus.entry_err), 0);
    req(1, 5, 0, 0, 300);
    chk("dbl_entry_err", 32'(bus.entry_err), 1);
    chk("dbl_occ", 32'(bus.occupied), 32'h20);
    tick();
    chk("dbl_entry_err_end", 32'(bus.entry_err), 0);
    req(0, 0, 1, 5, 450);
    expect_result("dbl_exit", 5, 250, 3, 15, 0);

    // Same-slot swap on occupied slot 3.
    req(1, 3, 0, 0, 10);
    req(1, 3, 1, 3, 110);
    chk("swap_no_entry_err", 32'(bus.entry_err), 0);
    chk("swap_occ", 32'(bus.occupied), 32'h08);
    expect_result("swap", 3, 100, 1, 5, 0);
    req(0, 0, 1, 3, 160);
    expect_result("swap_new_stamp", 3, 50, 1, 5, 0);

    // Zero-length stay still bills one unit.
    req(1, 1, 0, 0, 400);
    req(0, 0, 1, 1, 400);
    expect_result("zero", 1, 0, 1, 5, 0);

    // Same empty slot: entry accepted, exit errors.
    req(1, 6, 1, 6, 700);
    chk("same_empty_no_entry_err", 32'(bus.entry_err), 0);
    chk("same_empty_occ", 32'(bus.occupied), 32'h40);
    expect_result("same_empty", 6, 0, 0, 0, 1);

    // Different slots together: 700 -> 520 wraps to 820 ticks, 9 units.
    req(1, 4, 1, 6, 520);
    chk("diff_occ", 32'(bus.occupied), 32'h10);
    expect_result("diff", 6, 820, 9, 45, 0);

    // Saturation: 999 ticks at one tick per unit.
    sbus.entry_valid = 1'b1; sbus.entry_slot = 3'(0); sbus.timer_count = 10'(1);
    tick();
    sbus.entry_valid = 1'b0;
    sbus.exit_valid  = 1'b1; sbus.exit_slot = 3'(0); sbus.timer_count = 10'(0);
    tick();
    sbus.exit_valid  = 1'b0;
    k = 0;
    while (sbus.result_valid !== 1'b1 && k < WAIT_LIMIT) begin
      tick();
      k++;
    end
    chk("sat_valid", 32'(sbus.result_valid), 1);
    chk("sat_latency", 32'(k), FEE_EN ? 32'd999 : 32'd0);
    chk("sat_ticks", 32'(sbus.result_ticks), 999);
    chk("sat_fee", 32'(sbus.result_fee), FEE_EN ? 32'd255 : 32'd0);
    tick();

    // Reset one cycle into a 3-unit calculation aborts it.
    req(1, 7, 0, 0, 0);
    chk("abort_occ_in", 32'(bus.occupied), 32'h90);
    req(0, 0, 1, 7, 250);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_valid", 32'(bus.result_valid), 0);
    chk("abort_occ", 32'(bus.occupied), 0);
    chk("abort_ready", 32'(bus.ready), 1);
    seen = 0;
    repeat (6) begin
      tick();
      if (bus.result_valid === 1'b1) seen++;
    end
    chk("abort_no_result", 32'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_stay_meter.md
# parking_stay_meter

Consumer of the free-running 0–999 parking tick count: records each car's entry timestamp per slot and, on exit, computes the elapsed stay in ticks, handling wrap-around of the tick counter. When the fee feature is compiled in, it also computes a parking fee. Sits between the gate/sensor front end (entry/exit requests) and the display/billing logic (results).

## Interface
- SLOTS, 8: number of parking slots; SLOT_W = $clog2(SLOTS)
- UNIT_TICKS, 100: ticks per billing unit; must satisfy 1 ≤ UNIT_TICKS ≤ 999
- RATE, 5: fee per billing unit
- FEE_W, 8: fee width; the fee saturates at 2^FEE_W−1
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low; the block is in reset while reset==0 at a rising edge
- timer_count  in  10  tick count from the parking timer, range 0..999
- entry_valid  in  1  entry request, sampled only when ready==1
- entry_slot  in  SLOT_W  slot being entered
- exit_valid  in  1  exit request, sampled only when ready==1
- exit_slot  in  SLOT_W  slot being vacated
- ready  out  1  high in IDLE; requests are ignored when it is low
- occupied  out  SLOTS  per-slot occupancy bitmask
- entry_err  out  1  one-cycle pulse: entry rejected
- result_valid  out  1  one-cycle pulse: result fields valid
- result_slot  out  SLOT_W  slot of the completed exit
- result_ticks  out  10  elapsed stay, 0..999
- result_fee  out  FEE_W  computed fee (0 when the feature is compiled out)
- result_err  out  1  exit requested on an empty slot

## Operation
- Reset values: ready=1, occupied=0, entry_err=0, result_valid=0, result_slot=0, result_ticks=0, result_fee=0, result_err=0, state=IDLE. The timestamp table is not cleared. A reset asserted mid-CALC aborts the calculation with no result pulse.
- States and transitions:
  - IDLE → CALC on a valid exit to an occupied slot.
  - IDLE → DONE on an erroring exit, or on any valid exit when the feature is off.
  - CALC → DONE.
  - DONE → IDLE unconditionally.
- Entry in IDLE:
  - If the slot is free: stamp[slot] ← timer_count and occupied[slot] ← 1.
  - If the slot is occupied: entry_err pulses on the next cycle, and the stamp and occupancy are unchanged.
- Exit in IDLE on an occupied slot:
  - elapsed = timer_count ≥ stamp ? timer_count − stamp : timer_count + 1000 − stamp.
  - occupied[slot] is cleared.
  - Stays of 1000 ticks or more alias modulo 1000. This is accepted behaviour.
- Exit on an empty slot: DONE with result_err=1, result_ticks=0, result_fee=0.
- Simultaneous entry and exit on different slots: both are processed.
- Simultaneous entry and exit on the same occupied slot:
  - The exit uses the old stamp.
  - The entry writes the new stamp; occupied stays 1 and there is no entry_err.
- Simultaneous entry and exit on the same empty slot:
  - The entry is accepted.
  - The exit reports result_err.
- CALC (fee enabled):
  - units = max(1, ceil(elapsed/UNIT_TICKS)), computed by iterative subtraction.
  - Load: rem ← elapsed, units ← 1.
  - Each cycle: if rem > UNIT_TICKS, then rem −= UNIT_TICKS and units++; otherwise leave for DONE.
  - fee = units × RATE, saturated to FEE_W bits.

## Timing
- An exit sampled at edge N loads CALC at edge N+1.
- CALC lasts `units` cycles, and result_valid is high during the cycle following edge N+1+units.
- ready is low from edge N+1 until DONE ends, and returns high at edge N+2+units.
- Latency examples: elapsed 0 → result at N+2; elapsed 250 with UNIT_TICKS=100 → result at N+4.
- Error exit, or fee compiled out: result at N+1, ready high again at N+2.
- entry_err is high in the cycle after edge N.
- Result fields hold their values until the next result.

## Configuration
- PARKING_STAY_FEE_EN defined: CALC state, the divider and the fee logic are present.
- PARKING_STAY_FEE_EN undefined: no CALC state; a valid exit goes directly to DONE; result_fee is tied to 0; RATE and FEE_W are unused.

## Structure
- Package parking_pkg holds:
  - TICK_MOD=1000 and TICK_W=10
  - state enum {IDLE, CALC, DONE}
  - the wrap-aware elapsed-ticks function
- Sub-module parking_fee_divider: iterative subtract/count unit with a start/done handshake. It is instantiated only under PARKING_STAY_FEE_EN.

## Test plan
- Wrap-around: entry slot 2 at tick 980, exit at tick 30 → result_ticks=50, result_fee=5, result at N+2.
- Plain stay: entry slot 0 at tick 100, exit at tick 350 → result_ticks=250, units=3, result_fee=15, result_valid at N+4, ready low through DONE.
- Error paths:
  - Exit on empty slot 5 → result_err=1, result_ticks=0 at N+1.
  - Second entry on occupied slot 5 → entry_err pulse, stamp unchanged.
- Same-slot swap: entry and exit on slot 3 (stamp 10) at tick 110 → result_ticks=100, occupied[3] stays 1, stamp becomes 110.
- Saturation and no-charge case:
  - UNIT_TICKS=1, RATE=5, elapsed 999 → result_fee=255.
  - Elapsed 0 → units 1, fee 5.
- Reset and compile-out:
  - Reset asserted mid-CALC → no result_valid, occupied=0, ready=1 on the next cycle.
  - With PARKING_STAY_FEE_EN undefined, every exit yields its result at N+1 with result_fee=0.
